// File: rtl/hififo_rr_arbiter.sv
// rtl/hififo_rr_arbiter.sv - round-robin read-request arbiter for the from-PC FIFO channels
//
// Purpose:
//   Shares one PCIe read-request channel among 8 requesters: descriptor fetch
//   (RR0) and data fetch (RR1) of FIFO channels 0..3. A requester is masked
//   for HOLDOFF cycles after each grant. A global credit count limits the
//   number of 512-byte reads in flight. Credits come back on the last
//   completion beat, which is the beat carrying qword index 63.
//
// Ports:
//   clock, reset       system clock; synchronous active-high reset
//   rr_valid[7:0]      request valid; [3:0] RR0 of FIFO 0..3, [7:4] RR1 of FIFO 0..3
//   rr_addr[511:0]     byte address of requester i at [64*i +: 64]
//   rr1_tag[11:0]      data block index of FIFO f at [3*f +: 3]
//   rr_ready[7:0]      one-cycle accept pulse per requester
//   tx_valid/tx_ready  request handshake to the TLP generator
//   tx_addr[63:0]      512-byte aligned request address
//   tx_tag[7:0]        completion tag decoded by the FIFO channels
//   rc_valid, rc_index completion beat and its qword index
//   outstanding[4:0]   reads in flight
//   underflow          sticky flag: completion-last seen with nothing in flight

module hififo_rr_arbiter #(
   parameter int MAX_OUTSTANDING = 16,
   parameter int HOLDOFF         = 3
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [7:0]   rr_valid,
   input  logic [511:0] rr_addr,
   input  logic [11:0]  rr1_tag,
   output logic [7:0]   rr_ready,
   output logic         tx_valid,
   output logic [63:0]  tx_addr,
   output logic [7:0]   tx_tag,
   input  logic         tx_ready,
   input  logic         rc_valid,
   input  logic [5:0]   rc_index,
   output logic [4:0]   outstanding,
   output logic         underflow
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   state_t       state_q, state_d;
   logic [2:0]   ptr_q, ptr_d;
   logic [1:0]   holdoff_q [8];
   logic [1:0]   holdoff_d [8];
   logic [7:0]   rr_ready_q, rr_ready_d;
   logic         tx_valid_q, tx_valid_d;
   logic [63:0]  tx_addr_q, tx_addr_d;
   logic [7:0]   tx_tag_q, tx_tag_d;
   logic [4:0]   outstanding_q, outstanding_d;
   logic         underflow_q, underflow_d;

   logic [7:0]   eligible;
   logic         comp_last;
   logic [4:0]   credit_level;
   logic         room;
   logic         found;
   logic [2:0]   gnt_idx;
   logic [2:0]   cand_idx;
   logic         grant;
   logic [1:0]   gnt_fifo;
   logic [63:0]  addr_sel;
   logic [2:0]   blk_sel;
   logic         unused_addr_bits;

   assign comp_last = rc_valid & (rc_index == 6'd63);

   // Level used for the grant check: this cycle's credit return is applied
   // first, so a full arbiter can grant in the same cycle a read completes.
   assign credit_level = (comp_last && outstanding_q != 5'd0) ? outstanding_q - 5'd1
                                                            : outstanding_q;
   assign room = ({1'b0, credit_level} < 6'(MAX_OUTSTANDING));

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         eligible[i] = rr_valid[i] & (holdoff_q[i] == 2'd0);
      end
   end

   // Round-robin search starting at the pointer, wrapping 7 -> 0.
   always_comb begin
      found    = 1'b0;
      gnt_idx  = 3'd0;
      cand_idx = 3'd0;
      for (int k = 0; k < 8; k++) begin
         cand_idx = ptr_q + 3'(k);
         if (!found && eligible[cand_idx]) begin
            found   = 1'b1;
            gnt_idx = cand_idx;
         end
      end
   end

   assign grant    = (state_q == ST_IDLE) & found & room;
   assign gnt_fifo = gnt_idx[1:0];

   always_comb begin
      addr_sel = 64'd0;
      blk_sel  = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (gnt_idx == 3'(i)) begin
            addr_sel = rr_addr[64*i +: 64];
         end
      end
      for (int f = 0; f < 4; f++) begin
         if (gnt_fifo == 2'(f)) begin
            blk_sel = rr1_tag[3*f +: 3];
         end
      end
   end

   // Low address bits are dropped: every request is a whole 512-byte block.
   assign unused_addr_bits = ^addr_sel[8:0];

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      rr_ready_d    = 8'd0;
      tx_valid_d    = tx_valid_q;
      tx_addr_d     = tx_addr_q;
      tx_tag_d      = tx_tag_q;
      outstanding_d = outstanding_q;
      underflow_d   = underflow_q;
      for (int i = 0; i < 8; i++) begin
         holdoff_d[i] = (holdoff_q[i] != 2'd0) ? holdoff_q[i] - 2'd1 : 2'd0;
      end

      case (state_q)
         ST_IDLE: begin
            if (grant) begin
               state_d             = ST_ISSUE;
               tx_valid_d          = 1'b1;
               tx_addr_d           = {addr_sel[63:9], 9'd0};
               if (gnt_idx[2] == 1'b0) begin
                  tx_tag_d = {1'b1, 4'b0000, 1'b0, gnt_fifo};
               end else begin
                  tx_tag_d = {2'b00, gnt_fifo, 1'b0, blk_sel};
               end
               rr_ready_d[gnt_idx] = 1'b1;
               holdoff_d[gnt_idx]  = 2'(HOLDOFF);
               ptr_d               = gnt_idx + 3'd1;
            end
         end
         ST_ISSUE: begin
            if (tx_ready) begin
               state_d    = ST_IDLE;
               tx_valid_d = 1'b0;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A grant and a completion-last in the same cycle cancel out.
      if (grant && !comp_last) begin
         outstanding_d = outstanding_q + 5'd1;
      end else if (!grant && comp_last) begin
         if (outstanding_q == 5'd0) begin
            underflow_d = 1'b1;
         end else begin
            outstanding_d = outstanding_q - 5'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         ptr_q         <= 3'd0;
         rr_ready_q    <= 8'd0;
         tx_valid_q    <= 1'b0;
         tx_addr_q     <= 64'd0;
         tx_tag_q      <= 8'd0;
         outstanding_q <= 5'd0;
         underflow_q   <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            holdoff_q[i] <= 2'd0;
         end
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         rr_ready_q    <= rr_ready_d;
         tx_valid_q    <= tx_valid_d;
         tx_addr_q     <= tx_addr_d;
         tx_tag_q      <= tx_tag_d;
         outstanding_q <= outstanding_d;
         underflow_q   <= underflow_d;
         for (int i = 0; i < 8; i++) begin
            holdoff_q[i] <= holdoff_d[i];
         end
      end
   end

   assign rr_ready    = rr_ready_q;
   assign tx_valid    = tx_valid_q;
   assign tx_addr     = tx_addr_q;
   assign tx_tag      = tx_tag_q;
   assign outstanding = outstanding_q;
   assign underflow   = underflow_q;

endmodule
